// File: rtl/ras_stack_pkg.sv
// Shared frontend types for the return-address stack: pointer, occupancy and checkpoint layout.
// Depth and address width here set the widths used by ras_stack.
package ras_stack_pkg;

  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned RAS_VLEN  = 64;

  typedef logic [$clog2(RAS_DEPTH)-1:0]   ras_ptr_t;
  typedef logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt_t;

  typedef struct packed {
    ras_ptr_t              tp;
    ras_cnt_t              cnt;
    logic [RAS_VLEN-1:0]   top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: calls push pc+2/+4, returns pop, top of stack predicts the return target.
// Latency: push/pop visible the cycle after the edge; ra_o is a combinational read of stored state.
// Backpressure: none, one call/return accepted every cycle. Snapshot/restore built only with RAS_CKPT_EN.
module ras_stack
  import ras_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned VLEN  = RAS_VLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic            call_i,
  input  logic            return_i,
  input  logic            is_rvc_i,
  input  logic [VLEN-1:0] pc_i,
  input  logic            ckpt_i,
  input  logic            restore_i,
  output logic [VLEN-1:0] ra_o,
  output logic            ra_valid_o
);

  logic [VLEN-1:0] entries [DEPTH];
  ras_ptr_t        tp;
  ras_cnt_t        cnt;

  logic            push;
  logic            pop;
  logic            do_restore;
  logic [VLEN-1:0] ret_addr;
  ras_ptr_t        tp_inc;
  ras_ptr_t        tp_dec;
  ras_ckpt_t       snap;

  always_comb begin
    push     = valid_i & call_i;
    pop      = valid_i & return_i;
    ret_addr = pc_i + (is_rvc_i ? VLEN'(2) : VLEN'(4));
    tp_inc   = tp + 1'b1;
    tp_dec   = tp - 1'b1;
  end

  assign ra_o       = entries[tp];
  assign ra_valid_o = (cnt != '0);

`ifdef RAS_CKPT_EN
  assign do_restore = restore_i;

  // Snapshot is taken from pre-update state; a concurrent restore keeps the old snapshot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap <= '0;
    end else if (ckpt_i && !restore_i) begin
      snap <= '{tp: tp, cnt: cnt, top: entries[tp]};
    end
  end
`else
  logic unused_ckpt;
  assign do_restore  = 1'b0;
  assign snap        = '0;
  assign unused_ckpt = ckpt_i ^ restore_i ^ (|snap);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tp  <= '0;
      cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
    end else if (flush_i) begin
      tp  <= '0;
      cnt <= '0;
    end else if (do_restore) begin
      tp               <= snap.tp;
      cnt              <= snap.cnt;
      entries[snap.tp] <= snap.top;
    end else if (push && pop) begin
      // Coroutine swap: replace the top in place.
      entries[tp] <= ret_addr;
      if (cnt == '0) begin
        cnt <= ras_cnt_t'(1);
      end
    end else if (push) begin
      tp              <= tp_inc;
      entries[tp_inc] <= ret_addr;
      if (cnt != ras_cnt_t'(DEPTH)) begin
        cnt <= cnt + 1'b1;
      end
    end else if (pop && (cnt != '0)) begin
      tp  <= tp_dec;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: expected top/valid pushed to a scoreboard per cycle, popped after the edge.
module tb_ras_stack;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        call_i = 1'b0;
  logic        return_i = 1'b0;
  logic        is_rvc_i = 1'b0;
  logic [63:0] pc_i = '0;
  logic        ckpt_i = 1'b0;
  logic        restore_i = 1'b0;
  logic [63:0] ra_o;
  logic        ra_valid_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] ra;
    logic        vld;
  } exp_t;

  exp_t sb_q[$];

  ras_stack dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .call_i     (call_i),
    .return_i   (return_i),
    .is_rvc_i   (is_rvc_i),
    .pc_i       (pc_i),
    .ckpt_i     (ckpt_i),
    .restore_i  (restore_i),
    .ra_o       (ra_o),
    .ra_valid_o (ra_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then compare after the edge.
  task automatic cycle(input string tag, input logic v, input logic c, input logic r,
                       input logic rvc, input logic [63:0] pc, input logic fl,
                       input logic ck, input logic rs,
                       input logic [63:0] exp_ra, input logic exp_vld);
    exp_t e;
    @(negedge clk_i);
    valid_i = v; call_i = c; return_i = r; is_rvc_i = rvc; pc_i = pc;
    flush_i = fl; ckpt_i = ck; restore_i = rs;
    sb_q.push_back('{tag: tag, ra: exp_ra, vld: exp_vld});
    @(posedge clk_i);
    #1;
    valid_i = 0; call_i = 0; return_i = 0; flush_i = 0; ckpt_i = 0; restore_i = 0;
    e = sb_q.pop_front();
    chk({e.tag, ".ra"}, ra_o, e.ra);
    chk({e.tag, ".vld"}, {63'd0, ra_valid_o}, {63'd0, e.vld});
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk_i);
    rst_i = 1'b1;
    sb_q.push_back('{tag: tag, ra: 64'd0, vld: 1'b0});
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    e = sb_q.pop_front();
    chk({e.tag, ".ra"}, ra_o, e.ra);
    chk({e.tag, ".vld"}, {63'd0, ra_valid_o}, {63'd0, e.vld});
  endtask

  task automatic push_call(input string tag, input logic [63:0] pc, input logic rvc,
                           input logic [63:0] exp_ra);
    cycle(tag, 1, 1, 0, rvc, pc, 0, 0, 0, exp_ra, 1'b1);
  endtask

  task automatic pop_ret(input string tag, input logic [63:0] exp_ra, input logic exp_vld);
    cycle(tag, 1, 0, 1, 0, 64'h0, 0, 0, 0, exp_ra, exp_vld);
  endtask

  initial begin
    do_reset("reset0");

    // Plain 32-bit call
    push_call("call32", 64'h1000, 0, 64'h1004);

    // Compressed call then return; pre-edge top seen during the return cycle
    do_reset("reset1");
    push_call("call16", 64'h2002, 1, 64'h2004);
    @(negedge clk_i);
    valid_i = 1; return_i = 1;
    #1;
    chk("ret_same_cycle.ra", ra_o, 64'h2004);
    chk("ret_same_cycle.vld", {63'd0, ra_valid_o}, 64'd1);
    @(posedge clk_i);
    #1;
    valid_i = 0; return_i = 0;
    chk("ret_after.vld", {63'd0, ra_valid_o}, 64'd0);

    // Overflow by one then drain past empty
    do_reset("reset2");
    for (int k = 1; k <= 9; k++) begin
      push_call($sformatf("ovf_push%0d", k), 64'h100 * k, 0, 64'h100 * k + 64'h4);
    end
    for (int i = 1; i <= 7; i++) begin
      pop_ret($sformatf("drain%0d", i), 64'h100 * (9 - i) + 64'h4, 1'b1);
    end
    pop_ret("drain8", 64'h904, 1'b0);
    pop_ret("underflow", 64'h904, 1'b0);

    // Reset must clear the stored entries, not just the pointers
    do_reset("reset3");
    push_call("after_rst_call", 64'h10, 0, 64'h14);
    pop_ret("after_rst_pop", 64'h0, 1'b0);

    // Coroutine swap on a non-empty stack keeps count at 1
    do_reset("reset4");
    push_call("swap_setup", 64'h1000, 0, 64'h1004);
    cycle("swap", 1, 1, 1, 0, 64'h3000, 0, 0, 0, 64'h3004, 1'b1);
    pop_ret("swap_pop", 64'h0, 1'b0);

    // Swap on an empty stack makes count 1 without moving tp
    do_reset("reset5");
    cycle("swap_empty", 1, 1, 1, 1, 64'h40, 0, 0, 0, 64'h42, 1'b1);
    pop_ret("swap_empty_pop", 64'h0, 1'b0);

    // Call/return ignored without valid; address wraps modulo 2^64
    cycle("invalid_call", 0, 1, 0, 0, 64'h5000, 0, 0, 0, 64'h0, 1'b0);
    push_call("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h2);
    cycle("invalid_ret", 0, 0, 1, 0, 64'h0, 0, 0, 0, 64'h2, 1'b1);

    // Flush beats a same-cycle call
    do_reset("reset6");
    push_call("fl_push1", 64'h1000, 0, 64'h1004);
    push_call("fl_push2", 64'h2000, 0, 64'h2004);
    cycle("flush_call", 1, 1, 0, 0, 64'h6000, 1, 0, 0, 64'h0, 1'b0);
    pop_ret("flush_underflow", 64'h0, 1'b0);
    push_call("flush_repush", 64'h7000, 0, 64'h7004);

    // Checkpoint / restore sequence
    do_reset("reset7");
    push_call("ck_push", 64'h1000, 0, 64'h1004);
    cycle("ck_take", 0, 0, 0, 0, 64'h0, 0, 1, 0, 64'h1004, 1'b1);
    pop_ret("ck_pop", 64'h0, 1'b0);
    push_call("ck_spec_push", 64'h5000, 0, 64'h5004);
`ifdef RAS_CKPT_EN
    cycle("ck_restore", 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h1004, 1'b1);
    cycle("ck_with_push", 1, 1, 0, 0, 64'h8000, 0, 1, 0, 64'h8004, 1'b1);
    cycle("ck_and_restore", 0, 0, 0, 0, 64'h0, 0, 1, 1, 64'h1004, 1'b1);
    pop_ret("ck_restored_pop", 64'h0, 1'b0);
    cycle("ck_flush", 0, 0, 0, 0, 64'h0, 1, 0, 0, 64'h0, 1'b0);
    cycle("ck_after_flush", 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h1004, 1'b1);
`else
    cycle("ck_restore", 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h5004, 1'b1);
    cycle("ck_with_push", 1, 1, 0, 0, 64'h8000, 0, 1, 0, 64'h8004, 1'b1);
    cycle("ck_and_restore", 0, 0, 0, 0, 64'h0, 0, 1, 1, 64'h8004, 1'b1);
    cycle("ck_flush", 0, 0, 0, 0, 64'h0, 1, 0, 0, 64'h0, 1'b0);
    cycle("ck_after_flush", 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
